seq_detect_ctrl: RTL and testbench

//  Word-level controller for serial pattern detection. Accepts a DATA_W-bit word over a valid/ready

---
 rtl/seq_detect_pkg.sv | 17 +
 rtl/seq_detect_ctrl_pattern_matcher.sv | 39 +++
 rtl/seq_detect_ctrl.sv | 114 +++++++++++
 tb/tb_seq_detect_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared state encodings and defaults for the serial pattern detector
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int SD_DATA_W = 16;
  localparam int SD_PAT_W  = 4;
  localparam int SD_CNT_W  = 5;

  // first_idx value meaning "no hit in this word"; never a legal bit index
  localparam logic [SD_CNT_W-1:0] NO_HIT = {SD_CNT_W{1'b1}};

endpackage

// File: rtl/seq_detect_ctrl_pattern_matcher.sv
// rtl/seq_detect_ctrl_pattern_matcher.sv - overlapping serial matcher owning the history and fill count
module pattern_matcher #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit,
  output logic             filled
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  history;
  logic [PAT_W-1:0]  next_history;
  logic [FILL_W-1:0] fill;

  assign next_history = {history[PAT_W-2:0], bit_in};
  assign filled       = (fill == FILL_W'(PAT_W));
  // the incoming bit completes a full window once PAT_W-1 bits are already held
  assign hit          = en && (fill >= FILL_W'(PAT_W - 1)) && (next_history == pattern);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      history <= '0;
      fill    <= '0;
    end else if (clr) begin
      history <= '0;
      fill    <= '0;
    end else if (en) begin
      history <= next_history;
      if (!filled) fill <= fill + FILL_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - word-level controller: accept word, serialise MSB first, count hits, report
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int                DATA_W  = SD_DATA_W,
  parameter int                PAT_W   = SD_PAT_W,
  parameter int                CNT_W   = SD_CNT_W,
  parameter logic [PAT_W-1:0]  PAT_RST = 4'b1011
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_cfg_we,
  input  logic [PAT_W-1:0]  i_cfg_pat,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [DATA_W-1:0] i_s_data,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [CNT_W-1:0]  o_m_count,
  output logic [CNT_W-1:0]  o_m_first_idx,
  output logic              o_hit,
  output logic              o_busy
);

  localparam logic [CNT_W-1:0] NO_HIT_IDX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(DATA_W - 1);

  state_t            state;
  logic [PAT_W-1:0]  pattern;
  logic [DATA_W-1:0] data;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  first_idx;
  logic              hit;
  logic              hist_full;
  logic              take;

  assign take = (state == IDLE) && i_s_valid;

  pattern_matcher #(.PAT_W(PAT_W)) u_matcher (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (take),
    .en      (state == SHIFT),
    .bit_in  (data[DATA_W-1]),
    .pattern (pattern),
    .hit     (hit),
    .filled  (hist_full)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      pattern   <= PAT_RST;
      data      <= '0;
      idx       <= '0;
      count     <= '0;
      first_idx <= NO_HIT_IDX;
      o_s_ready <= 1'b1;
      o_m_valid <= 1'b0;
      o_hit     <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      o_hit <= hit;
      case (state)
        IDLE: begin
          // a coinciding config write takes effect before the first bit is matched
          if (i_cfg_we) pattern <= i_cfg_pat;
          if (take) begin
            data      <= i_s_data;
            idx       <= '0;
            count     <= '0;
            first_idx <= NO_HIT_IDX;
            state     <= SHIFT;
            o_s_ready <= 1'b0;
            o_busy    <= 1'b1;
          end
        end
        SHIFT: begin
          data <= {data[DATA_W-2:0], 1'b0};
          idx  <= idx + CNT_W'(1);
          if (hit) begin
            count <= count + CNT_W'(1);
            if (first_idx == NO_HIT_IDX) first_idx <= idx;
          end
          if (idx == LAST_IDX) begin
            state     <= REPORT;
            o_m_valid <= 1'b1;
          end
        end
        REPORT: begin
          if (i_m_ready) begin
            state     <= IDLE;
            o_m_valid <= 1'b0;
            o_s_ready <= 1'b1;
            o_busy    <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          o_m_valid <= 1'b0;
          o_s_ready <= 1'b1;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign o_m_count     = count;
  assign o_m_first_idx = first_idx;

  a_full_in_report: assert property (@(posedge clk) disable iff (!rstn) (state == REPORT) |-> hist_full);

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - directed table-driven bench for seq_detect_ctrl
module tb_seq_detect_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_cfg_we;
  logic [3:0]  i_cfg_pat;
  logic        i_s_valid;
  logic        o_s_ready;
  logic [15:0] i_s_data;
  logic        o_m_valid;
  logic        i_m_ready;
  logic [4:0]  o_m_count;
  logic [4:0]  o_m_first_idx;
  logic        o_hit;
  logic        o_busy;

  int checks   = 0;
  int failures = 0;

  seq_detect_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_cfg_we      (i_cfg_we),
    .i_cfg_pat     (i_cfg_pat),
    .i_s_valid     (i_s_valid),
    .o_s_ready     (o_s_ready),
    .i_s_data      (i_s_data),
    .o_m_valid     (o_m_valid),
    .i_m_ready     (i_m_ready),
    .o_m_count     (o_m_count),
    .o_m_first_idx (o_m_first_idx),
    .o_hit         (o_hit),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wr;
    logic [3:0]  pat;
    logic [15:0] data;
    logic [4:0]  cnt;
    logic [4:0]  first;
    logic [15:0] mask;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the last bit's edge.
  task automatic run_word(input logic [15:0] data, input logic wr, input logic [3:0] pat,
                          input logic mid_cfg, output logic [15:0] mask, output logic early);
    mask  = '0;
    early = 1'b0;
    chk("s_ready_before_word", o_s_ready, 1);
    i_s_valid = 1'b1;
    i_s_data  = data;
    i_cfg_we  = wr;
    i_cfg_pat = pat;
    cycle();
    i_cfg_we = 1'b0;
    i_s_data = ~data;
    for (int j = 1; j <= 16; j++) begin
      i_s_valid = (j < 16);
      if (j == 5 && mid_cfg) begin
        i_cfg_we  = 1'b1;
        i_cfg_pat = 4'b0000;
      end
      cycle();
      i_cfg_we = 1'b0;
      mask[j-1] = o_hit;
      if (j < 16 && o_m_valid) early = 1'b1;
    end
    i_s_valid = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [4:0] cnt, input logic [4:0] first,
                              input logic [15:0] exp_mask, input logic [15:0] mask, input logic early);
    chk({name, "_valid"}, o_m_valid, 1);
    chk({name, "_early"}, early, 0);
    chk({name, "_count"}, o_m_count, cnt);
    chk({name, "_first"}, o_m_first_idx, first);
    chk({name, "_hits"}, mask, exp_mask);
  endtask

  task automatic finish_report(input string name);
    cycle();
    chk({name, "_valid_drop"}, o_m_valid, 0);
    chk({name, "_ready_back"}, o_s_ready, 1);
  endtask

  logic [15:0] mask;
  logic        early;
  logic        stable;
  int          acc[$];
  int          period;
  logic        seen_valid;
  logic        drained;

  initial begin
    vecs[0] = '{"b000",      1'b0, 4'b0000, 16'hB000, 5'd1,  5'd3,  16'h0008};
    vecs[1] = '{"overlap",   1'b0, 4'b0000, 16'hB6C0, 5'd3,  5'd3,  16'h0248};
    vecs[2] = '{"zero",      1'b0, 4'b0000, 16'h0000, 5'd0,  5'h1F, 16'h0000};
    vecs[3] = '{"pat0_zero", 1'b1, 4'b0000, 16'h0000, 5'd13, 5'd3,  16'hFFF8};
    vecs[4] = '{"last_bit",  1'b1, 4'b1011, 16'h000B, 5'd1,  5'd15, 16'h8000};
    vecs[5] = '{"bbbb",      1'b0, 4'b0000, 16'hBBBB, 5'd4,  5'd3,  16'h8888};

    rstn      = 1'b0;
    i_cfg_we  = 1'b0;
    i_cfg_pat = 4'b0000;
    i_s_valid = 1'b0;
    i_s_data  = 16'h0;
    i_m_ready = 1'b1;
    repeat (3) cycle();
    chk("rst_s_ready", o_s_ready, 1);
    chk("rst_m_valid", o_m_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_count", o_m_count, 0);
    chk("rst_first", o_m_first_idx, 5'h1F);
    chk("rst_hit", o_hit, 0);
    rstn = 1'b1;
    cycle();

    for (int v = 0; v < 6; v++) begin
      run_word(vecs[v].data, vecs[v].wr, vecs[v].pat, 1'b0, mask, early);
      check_result(vecs[v].name, vecs[v].cnt, vecs[v].first, vecs[v].mask, mask, early);
      finish_report(vecs[v].name);
    end

    // pattern write during SHIFT must not affect this word or the next
    run_word(16'hB000, 1'b0, 4'b0000, 1'b1, mask, early);
    check_result("midcfg_cur", 5'd1, 5'd3, 16'h0008, mask, early);
    finish_report("midcfg_cur");
    run_word(16'hB000, 1'b0, 4'b0000, 1'b0, mask, early);
    check_result("midcfg_next", 5'd1, 5'd3, 16'h0008, mask, early);
    finish_report("midcfg_next");

    // backpressure: hold REPORT for 5 cycles while offering a new word
    i_m_ready = 1'b0;
    run_word(16'hB6C0, 1'b0, 4'b0000, 1'b0, mask, early);
    check_result("bp", 5'd3, 5'd3, 16'h0248, mask, early);
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_s_valid = 1'b1;
      i_s_data  = 16'hBBBB;
      cycle();
      if (!(o_m_valid && o_m_count == 5'd3 && o_m_first_idx == 5'd3 && !o_s_ready && o_busy))
        stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    i_s_valid = 1'b0;
    i_m_ready = 1'b1;
    finish_report("bp");

    // back-to-back words with valid held high: accept period
    i_s_valid = 1'b1;
    i_s_data  = 16'hB000;
    for (int c = 0; c < 60 && acc.size() < 2; c++) begin
      if (o_s_ready) acc.push_back(c);
      cycle();
    end
    i_s_valid = 1'b0;
    period = (acc.size() == 2) ? acc[1] - acc[0] : -1;
    chk("b2b_period", period, 18);
    drained = 1'b0;
    for (int c = 0; c < 40 && !drained; c++) begin
      if (o_s_ready && !o_busy) drained = 1'b1;
      else cycle();
    end
    chk("b2b_drain", drained, 1);

    // reset mid-SHIFT after bit 7, with a non-default pattern loaded
    i_cfg_we  = 1'b1;
    i_cfg_pat = 4'b0000;
    cycle();
    i_cfg_we  = 1'b0;
    i_s_valid = 1'b1;
    i_s_data  = 16'hB000;
    cycle();
    i_s_valid = 1'b0;
    repeat (8) cycle();
    rstn = 1'b0;
    #1;
    chk("mrst_s_ready", o_s_ready, 1);
    chk("mrst_m_valid", o_m_valid, 0);
    chk("mrst_busy", o_busy, 0);
    chk("mrst_count", o_m_count, 0);
    chk("mrst_first", o_m_first_idx, 5'h1F);
    chk("mrst_hit", o_hit, 0);
    @(negedge clk);
    cycle();
    rstn = 1'b1;
    seen_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (o_m_valid) seen_valid = 1'b1;
    end
    chk("mrst_no_result", seen_valid, 0);
    run_word(16'hB000, 1'b0, 4'b0000, 1'b0, mask, early);
    check_result("mrst_pat", 5'd1, 5'd3, 16'h0008, mask, early);
    finish_report("mrst_pat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
